// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and limits for the bit-serial adder.
// Holds the FSM state encoding and the supported operand width ceiling.
// No logic; imported by serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_adder_state_t;

  localparam int SERIAL_ADDER_MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder (bit slice of serial_adder).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; no handshake.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands one bit per cycle, LSB first, via one full_adder.
// Latency: out_valid WIDTH cycles after accept; next accept the cycle after pop (II = WIDTH+2).
// Backpressure: in_ready only in IDLE; result held frozen in DONE until out_ready.
// Optional: define SERIAL_ADDER_SUB_EN to add the in_sub port (A - B, cout=1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  // Counter needs at least one bit so WIDTH = 1 still has a legal vector.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = res_q;
  assign out_cout  = carry_q;

  // Next-state and datapath: load on accept, shift one bit per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert B and force the +1 through the carry.
          if (in_sub) begin
            b_d     = ~in_b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
        res_d   = WIDTH'({fa_sum, res_q} >> 1);
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector bench for serial_adder at WIDTH = 8 and WIDTH = 1.
// Covers reset values, latency, wrap-around, back-pressure, mid-run reset, optional subtract.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract vectors.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 8 instance signals
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_cin = 1'b0;
  logic       in_sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_cout;

  // WIDTH = 1 instance signals
  logic       w1_in_valid = 1'b0;
  logic       w1_in_ready;
  logic [0:0] w1_in_a = 1'b0;
  logic [0:0] w1_in_b = 1'b0;
  logic       w1_in_cin = 1'b0;
  logic       w1_in_sub = 1'b0;
  logic       w1_out_valid;
  logic       w1_out_ready = 1'b0;
  logic [0:0] w1_out_sum;
  logic       w1_out_cout;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  serial_adder #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .in_a      (w1_in_a),
    .in_b      (w1_in_b),
    .in_cin    (w1_in_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (w1_in_sub),
`endif
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .out_sum   (w1_out_sum),
    .out_cout  (w1_out_cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present one operand set on the WIDTH = 8 port and let it be accepted (returns just after E0).
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    @(negedge clk);
    check("launch_in_ready", {63'd0, in_ready}, 64'd1);
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("accepted_in_ready_low", {63'd0, in_ready}, 64'd0);
  endtask

  // Count edges after E0 until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({nm, "_pop_in_ready"}, {63'd0, in_ready}, 64'd1);
    check({nm, "_pop_out_valid"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string nm, input vec_t v);
    int lat;
    launch(v.a, v.b, v.cin, v.sub);
    wait_valid(lat);
    check({nm, "_latency"}, 64'(lat), 64'd8);
    check({nm, "_sum"}, {56'd0, out_sum}, {56'd0, v.sum});
    check({nm, "_cout"}, {63'd0, out_cout}, {63'd0, v.cout});
    pop(nm);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs.push_back('{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, sum: 8'h96, cout: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h00, cout: 1'b1});
    vecs.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, sum: 8'hFF, cout: 1'b1});
    vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, sum: 8'h01, cout: 1'b0});
    vecs.push_back('{a: 8'h80, b: 8'h80, cin: 1'b0, sub: 1'b0, sum: 8'h00, cout: 1'b1});
    vecs.push_back('{a: 8'hAA, b: 8'h55, cin: 1'b1, sub: 1'b0, sum: 8'h00, cout: 1'b1});
    vecs.push_back('{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h80, cout: 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{a: 8'h10, b: 8'h01, cin: 1'b0, sub: 1'b1, sum: 8'h0F, cout: 1'b1});
    vecs.push_back('{a: 8'h00, b: 8'h01, cin: 1'b0, sub: 1'b1, sum: 8'hFF, cout: 1'b0});
    vecs.push_back('{a: 8'h10, b: 8'h01, cin: 1'b1, sub: 1'b1, sum: 8'h0F, cout: 1'b1});
    vecs.push_back('{a: 8'h05, b: 8'h05, cin: 1'b0, sub: 1'b1, sum: 8'h00, cout: 1'b1});
`endif

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {56'd0, out_sum}, 64'd0);
    check("rst_out_cout", {63'd0, out_cout}, 64'd0);
    check("rst_w1_in_ready", {63'd0, w1_in_ready}, 64'd1);
    check("rst_w1_out_valid", {63'd0, w1_out_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-pressure: hold DONE for 5 cycles while in_a churns.
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_a = in_a ^ 8'hFF ^ 8'(i);
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_%0d", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp_sum_%0d", i), {56'd0, out_sum}, 64'h46);
      check($sformatf("bp_cout_%0d", i), {63'd0, out_cout}, 64'd0);
      check($sformatf("bp_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
    end
    pop("bp");

    // Reset three cycles into RUN aborts the operation.
    launch(8'hF0, 8'h0F, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("midrst_stays_idle", {63'd0, seen}, 64'd0);
    do_op("post_rst", '{a: 8'h01, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h02, cout: 1'b0});

    // WIDTH = 1: a single RUN cycle.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("w1_%0d_in_ready", k), {63'd0, w1_in_ready}, 64'd1);
      w1_in_a = 1'b1;
      w1_in_b = (k == 0) ? 1'b1 : 1'b0;
      w1_in_cin = (k == 0) ? 1'b1 : 1'b0;
      w1_in_valid = 1'b1;
      @(posedge clk);
      #1;
      w1_in_valid = 1'b0;
      check($sformatf("w1_%0d_run_valid", k), {63'd0, w1_out_valid}, 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("w1_%0d_done_valid", k), {63'd0, w1_out_valid}, 64'd1);
      check($sformatf("w1_%0d_sum", k), {63'd0, w1_out_sum}, 64'd1);
      check($sformatf("w1_%0d_cout", k), {63'd0, w1_out_cout}, (k == 0) ? 64'd1 : 64'd0);
      @(negedge clk);
      w1_out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("w1_%0d_pop_in_ready", k), {63'd0, w1_in_ready}, 64'd1);
      @(negedge clk);
      w1_out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
